// File: rtl/dm_pkg.sv
// Shared encodings, sizes and lane payload type for the data memory unit.
package dm_pkg;

  localparam int unsigned DM_DEPTH_WORDS = 1024;
  localparam int unsigned DM_WORD_W      = 32;
  localparam int unsigned DM_BYTE_W      = 8;
  localparam int unsigned DM_LANES       = DM_WORD_W / DM_BYTE_W;

  typedef enum logic [2:0] {
    LD_NONE = 3'b000,
    LD_W    = 3'b001,
    LD_H    = 3'b010,
    LD_HU   = 3'b011,
    LD_B    = 3'b100,
    LD_BU   = 3'b101,
    LD_WL   = 3'b110,
    LD_WR   = 3'b111
  } ld_type_e;

  typedef enum logic [1:0] {
    SW_NORMAL = 2'b00,
    SW_LEFT   = 2'b01,
    SW_RIGHT  = 2'b10,
    SW_RSVD   = 2'b11
  } sw_mode_e;

  typedef enum logic [1:0] {
    ST_WORD = 2'b00,
    ST_HALF = 2'b01,
    ST_BYTE = 2'b10,
    ST_RSVD = 2'b11
  } st_size_e;

  // Per-lane write payload: byte enables plus lane-aligned data.
  typedef struct packed {
    logic [DM_LANES-1:0]  be;
    logic [DM_WORD_W-1:0] data;
  } dm_wr_lanes_t;

endpackage : dm_pkg

// File: rtl/dm_load_ext.sv
// Load result formation: lane select, sign/zero extension, lwl/lwr merge with rt.
module dm_load_ext
  import dm_pkg::*;
(
  input  ld_type_e              ld_type_i,
  input  logic [1:0]            offset_i,
  input  logic [DM_WORD_W-1:0]  raw_i,
  input  logic [DM_WORD_W-1:0]  rt_old_i,
  output logic [DM_WORD_W-1:0]  result_c_o
);

  logic [15:0] half_c;
  logic [7:0]  byte_c;

  // Select the addressed half/byte lane out of the raw word.
  always_comb begin
    half_c = offset_i[1] ? raw_i[31:16] : raw_i[15:0];
    byte_c = raw_i[{offset_i, 3'b000} +: 8];
  end

  // Extend or merge the selected memory bytes into the final register value.
  always_comb begin
    result_c_o = raw_i;
    case (ld_type_i)
      LD_W:    result_c_o = raw_i;
      LD_H:    result_c_o = {{16{half_c[15]}}, half_c};
      LD_HU:   result_c_o = {16'h0000, half_c};
      LD_B:    result_c_o = {{24{byte_c[7]}}, byte_c};
      LD_BU:   result_c_o = {24'h000000, byte_c};
      LD_WL: begin
        // Memory bytes 0..k land in the top k+1 bytes; low bytes keep rt.
        case (offset_i)
          2'd0:    result_c_o = {raw_i[7:0],  rt_old_i[23:0]};
          2'd1:    result_c_o = {raw_i[15:0], rt_old_i[15:0]};
          2'd2:    result_c_o = {raw_i[23:0], rt_old_i[7:0]};
          default: result_c_o = raw_i;
        endcase
      end
      LD_WR: begin
        // Memory bytes k..3 land in the low 4-k bytes; high bytes keep rt.
        case (offset_i)
          2'd1:    result_c_o = {rt_old_i[31:24], raw_i[31:8]};
          2'd2:    result_c_o = {rt_old_i[31:16], raw_i[31:16]};
          2'd3:    result_c_o = {rt_old_i[31:8],  raw_i[31:24]};
          default: result_c_o = raw_i;
        endcase
      end
      default: result_c_o = raw_i;
    endcase
  end

endmodule : dm_load_ext

// File: rtl/data_mem_unit.sv
// M-stage data memory: byte-lane stores incl. swl/swr, 1-cycle loads into W registers.
module data_mem_unit
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DM_DEPTH_WORDS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  input  logic                 mem_write,
  input  logic [1:0]           sw_mode,
  input  logic [1:0]           st_size,
  input  logic [2:0]           ld_type,
  input  logic [31:0]          rt_old,
  output logic [31:0]          rdata_w,
  output logic                 ld_valid_w,
  output logic                 addr_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  logic [DM_WORD_W-1:0] mem_q [DEPTH_WORDS];

  ld_type_e             ld_type_c;
  sw_mode_e             sw_mode_c;
  st_size_e             st_size_c;
  logic [1:0]           offset_c;
  logic [IDX_W-1:0]     word_idx_c;
  logic [DM_WORD_W-1:0] rd_word_c;
  logic [DM_WORD_W-1:0] ld_result_c;
  dm_wr_lanes_t         lanes_c;
  logic                 normal_st_c;
  logic                 st_word_c;
  logic                 st_half_c;
  logic                 wr_en_c;
  logic [DM_WORD_W-1:0] wr_word_d;
  logic [DM_WORD_W-1:0] rdata_d, rdata_q;
  logic                 ld_valid_d, ld_valid_q;
  logic                 unused_addr_bits;

  // Address decode; bits above the depth range alias and are ignored.
  always_comb begin
    ld_type_c  = ld_type_e'(ld_type);
    sw_mode_c  = sw_mode_e'(sw_mode);
    st_size_c  = st_size_e'(st_size);
    offset_c   = addr[1:0];
    word_idx_c = addr[IDX_W+1:2];
    rd_word_c  = mem_q[word_idx_c];
  end

  assign unused_addr_bits = ^addr[31:IDX_W+2];

  // Misalignment detection for word and half accesses (swl/swr/lwl/lwr/byte never fault).
  always_comb begin
    normal_st_c = mem_write && ((sw_mode_c == SW_NORMAL) || (sw_mode_c == SW_RSVD));
    st_half_c   = normal_st_c && (st_size_c == ST_HALF);
    st_word_c   = normal_st_c && (st_size_c != ST_HALF) && (st_size_c != ST_BYTE);
    addr_err    = (((ld_type_c == LD_W) || st_word_c) && (offset_c != 2'b00)) ||
                  (((ld_type_c == LD_H) || (ld_type_c == LD_HU) || st_half_c) && offset_c[0]);
  end

  // Byte-enable and lane-aligned data generation for every store flavour.
  always_comb begin
    lanes_c.be   = 4'b1111;
    lanes_c.data = wdata;
    case (sw_mode_c)
      SW_LEFT: begin
        case (offset_c)
          2'd0:    begin lanes_c.be = 4'b0001; lanes_c.data = {24'h000000, wdata[31:24]}; end
          2'd1:    begin lanes_c.be = 4'b0011; lanes_c.data = {16'h0000, wdata[31:16]};   end
          2'd2:    begin lanes_c.be = 4'b0111; lanes_c.data = {8'h00, wdata[31:8]};       end
          default: begin lanes_c.be = 4'b1111; lanes_c.data = wdata;                      end
        endcase
      end
      SW_RIGHT: begin
        case (offset_c)
          2'd1:    begin lanes_c.be = 4'b1110; lanes_c.data = {wdata[23:0], 8'h00};       end
          2'd2:    begin lanes_c.be = 4'b1100; lanes_c.data = {wdata[15:0], 16'h0000};    end
          2'd3:    begin lanes_c.be = 4'b1000; lanes_c.data = {wdata[7:0], 24'h000000};   end
          default: begin lanes_c.be = 4'b1111; lanes_c.data = wdata;                      end
        endcase
      end
      default: begin
        case (st_size_c)
          ST_HALF: begin
            lanes_c.be   = offset_c[1] ? 4'b1100 : 4'b0011;
            lanes_c.data = {wdata[15:0], wdata[15:0]};
          end
          ST_BYTE: begin
            lanes_c.be   = 4'(4'b0001 << offset_c);
            lanes_c.data = {4{wdata[7:0]}};
          end
          default: begin
            lanes_c.be   = 4'b1111;
            lanes_c.data = wdata;
          end
        endcase
      end
    endcase
  end

  // Merge enabled lanes over the current word contents.
  always_comb begin
    wr_en_c = mem_write && !addr_err;
    for (int j = 0; j < int'(DM_LANES); j++) begin
      wr_word_d[j*8 +: 8] = lanes_c.be[j] ? lanes_c.data[j*8 +: 8] : rd_word_c[j*8 +: 8];
    end
  end

  // Memory array: cleared on reset, otherwise one word written per edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_c) begin
      mem_q[word_idx_c] <= wr_word_d;
    end
  end

  dm_load_ext u_load_ext (
    .ld_type_i  (ld_type_c),
    .offset_i   (offset_c),
    .raw_i      (rd_word_c),
    .rt_old_i   (rt_old),
    .result_c_o (ld_result_c)
  );

  // W-stage next state: capture a valid load, otherwise hold data and drop valid.
  always_comb begin
    rdata_d    = rdata_q;
    ld_valid_d = 1'b0;
    if ((ld_type_c != LD_NONE) && !addr_err) begin
      rdata_d    = ld_result_c;
      ld_valid_d = 1'b1;
    end
  end

  // W-stage registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q    <= '0;
      ld_valid_q <= 1'b0;
    end else begin
      rdata_q    <= rdata_d;
      ld_valid_q <= ld_valid_d;
    end
  end

  assign rdata_w    = rdata_q;
  assign ld_valid_w = ld_valid_q;

endmodule : data_mem_unit

// File: tb/tb_data_mem_unit.sv
// Directed self-checking bench for data_mem_unit.
module tb_data_mem_unit;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_write;
  logic [1:0]  sw_mode;
  logic [1:0]  st_size;
  logic [2:0]  ld_type;
  logic [31:0] rt_old;
  logic [31:0] rdata_w;
  logic        ld_valid_w;
  logic        addr_err;

  int checks = 0;
  int errors = 0;

  data_mem_unit dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .wdata      (wdata),
    .mem_write  (mem_write),
    .sw_mode    (sw_mode),
    .st_size    (st_size),
    .ld_type    (ld_type),
    .rt_old     (rt_old),
    .rdata_w    (rdata_w),
    .ld_valid_w (ld_valid_w),
    .addr_err   (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    mem_write = 1'b0;
    sw_mode   = 2'b00;
    st_size   = 2'b00;
    ld_type   = 3'b000;
    addr      = 32'h0;
    wdata     = 32'h0;
    rt_old    = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] mode, input logic [1:0] size);
    idle();
    addr = a; wdata = d; sw_mode = mode; st_size = size; mem_write = 1'b1;
    tick();
    idle();
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] lt, input logic [31:0] rt);
    idle();
    addr = a; ld_type = lt; rt_old = rt;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    if (rdata_w !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected %h", rdata_w, 32'h0); end
    checks++;
    if (ld_valid_w !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", ld_valid_w); end
    checks++;
    addr = 32'h1; ld_type = 3'b001;
    #1;
    if (addr_err !== 1'b1) begin errors++; $display("FAIL reset_addr_err_comb: got %b expected 1", addr_err); end
    checks++;
    idle();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_store_load();
    do_store(32'h10, 32'h11223344, 2'b00, 2'b00);
    do_load(32'h10, 3'b001, 32'h0);
    if (rdata_w !== 32'h11223344) begin errors++; $display("FAIL lw_0x10: got %h expected %h", rdata_w, 32'h11223344); end
    checks++;
    if (ld_valid_w !== 1'b1) begin errors++; $display("FAIL lw_0x10_valid: got %b expected 1", ld_valid_w); end
    checks++;
    tick();
    if (ld_valid_w !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b expected 0", ld_valid_w); end
    checks++;
    if (rdata_w !== 32'h11223344) begin errors++; $display("FAIL idle_hold: got %h expected %h", rdata_w, 32'h11223344); end
    checks++;
  endtask

  task automatic test_sub_word_loads();
    logic [31:0] exp_v [5];
    logic [31:0] adr_v [5];
    logic [2:0]  typ_v [5];
    do_load(32'h13, 3'b100, 32'h0);
    if (rdata_w !== 32'h00000011) begin errors++; $display("FAIL lb_0x13: got %h expected %h", rdata_w, 32'h00000011); end
    checks++;
    do_store(32'h10, 32'h800000FF, 2'b00, 2'b00);
    adr_v[0] = 32'h10; typ_v[0] = 3'b100; exp_v[0] = 32'hFFFFFFFF;
    adr_v[1] = 32'h12; typ_v[1] = 3'b011; exp_v[1] = 32'h00008000;
    adr_v[2] = 32'h12; typ_v[2] = 3'b010; exp_v[2] = 32'hFFFF8000;
    adr_v[3] = 32'h10; typ_v[3] = 3'b101; exp_v[3] = 32'h000000FF;
    adr_v[4] = 32'h10; typ_v[4] = 3'b010; exp_v[4] = 32'h000000FF;
    for (int i = 0; i < 5; i++) begin
      do_load(adr_v[i], typ_v[i], 32'h0);
      if (rdata_w !== exp_v[i]) begin
        errors++;
        $display("FAIL subword_%0d addr %h type %b: got %h expected %h", i, adr_v[i], typ_v[i], rdata_w, exp_v[i]);
      end
      checks++;
    end
  endtask

  task automatic test_partial_stores();
    do_store(32'h60, 32'h00000000, 2'b00, 2'b00);
    do_store(32'h62, 32'h1234BEEF, 2'b00, 2'b01);
    do_store(32'h61, 32'h0000005A, 2'b00, 2'b10);
    do_load(32'h60, 3'b001, 32'h0);
    if (rdata_w !== 32'hBEEF5A00) begin errors++; $display("FAIL sh_sb_merge: got %h expected %h", rdata_w, 32'hBEEF5A00); end
    checks++;
  endtask

  task automatic test_swl_swr();
    logic [31:0] adr_v [4];
    logic [1:0]  mod_v [4];
    logic [31:0] exp_v [4];
    adr_v[0] = 32'h21; mod_v[0] = 2'b01; exp_v[0] = 32'hAABB1122;
    adr_v[1] = 32'h22; mod_v[1] = 2'b10; exp_v[1] = 32'h3344CCDD;
    adr_v[2] = 32'h20; mod_v[2] = 2'b01; exp_v[2] = 32'hAABBCC11;
    adr_v[3] = 32'h23; mod_v[3] = 2'b10; exp_v[3] = 32'h44BBCCDD;
    for (int i = 0; i < 4; i++) begin
      do_store(32'h20, 32'hAABBCCDD, 2'b00, 2'b00);
      do_store(adr_v[i], 32'h11223344, mod_v[i], 2'b00);
      do_load(32'h20, 3'b001, 32'h0);
      if (rdata_w !== exp_v[i]) begin
        errors++;
        $display("FAIL swlr_%0d addr %h mode %b: got %h expected %h", i, adr_v[i], mod_v[i], rdata_w, exp_v[i]);
      end
      checks++;
    end
  endtask

  task automatic test_lwl_lwr();
    logic [31:0] adr_v [6];
    logic [2:0]  typ_v [6];
    logic [31:0] exp_v [6];
    adr_v[0] = 32'h31; typ_v[0] = 3'b110; exp_v[0] = 32'hCCDD3344;
    adr_v[1] = 32'h32; typ_v[1] = 3'b111; exp_v[1] = 32'h1122AABB;
    adr_v[2] = 32'h33; typ_v[2] = 3'b110; exp_v[2] = 32'hAABBCCDD;
    adr_v[3] = 32'h30; typ_v[3] = 3'b111; exp_v[3] = 32'hAABBCCDD;
    adr_v[4] = 32'h30; typ_v[4] = 3'b110; exp_v[4] = 32'hDD223344;
    adr_v[5] = 32'h33; typ_v[5] = 3'b111; exp_v[5] = 32'h112233AA;
    do_store(32'h30, 32'hAABBCCDD, 2'b00, 2'b00);
    for (int i = 0; i < 6; i++) begin
      do_load(adr_v[i], typ_v[i], 32'h11223344);
      if (rdata_w !== exp_v[i]) begin
        errors++;
        $display("FAIL lwlr_%0d addr %h type %b: got %h expected %h", i, adr_v[i], typ_v[i], rdata_w, exp_v[i]);
      end
      checks++;
    end
  endtask

  task automatic test_misaligned();
    do_store(32'h40, 32'hCAFEF00D, 2'b00, 2'b00);
    idle();
    addr = 32'h41; wdata = 32'h12345678; mem_write = 1'b1;
    #1;
    if (addr_err !== 1'b1) begin errors++; $display("FAIL sw_0x41_err: got %b expected 1", addr_err); end
    checks++;
    tick();
    do_load(32'h40, 3'b001, 32'h0);
    if (rdata_w !== 32'hCAFEF00D) begin errors++; $display("FAIL sw_0x41_suppressed: got %h expected %h", rdata_w, 32'hCAFEF00D); end
    checks++;
    idle();
    addr = 32'h43; ld_type = 3'b010;
    #1;
    if (addr_err !== 1'b1) begin errors++; $display("FAIL lh_0x43_err: got %b expected 1", addr_err); end
    checks++;
    tick();
    if (ld_valid_w !== 1'b0) begin errors++; $display("FAIL lh_0x43_valid: got %b expected 0", ld_valid_w); end
    checks++;
    if (rdata_w !== 32'hCAFEF00D) begin errors++; $display("FAIL lh_0x43_hold: got %h expected %h", rdata_w, 32'hCAFEF00D); end
    checks++;
    idle();
    addr = 32'h41; mem_write = 1'b1; sw_mode = 2'b01;
    #1;
    if (addr_err !== 1'b0) begin errors++; $display("FAIL swl_0x41_err: got %b expected 0", addr_err); end
    checks++;
    idle();
    addr = 32'h43; ld_type = 3'b100;
    #1;
    if (addr_err !== 1'b0) begin errors++; $display("FAIL lb_0x43_err: got %b expected 0", addr_err); end
    checks++;
    addr = 32'h42; ld_type = 3'b011;
    #1;
    if (addr_err !== 1'b0) begin errors++; $display("FAIL lhu_0x42_err: got %b expected 0", addr_err); end
    checks++;
    idle();
    addr = 32'h42; mem_write = 1'b1; st_size = 2'b00;
    #1;
    if (addr_err !== 1'b1) begin errors++; $display("FAIL sw_0x42_err: got %b expected 1", addr_err); end
    checks++;
    idle();
    #1;
  endtask

  task automatic test_back_to_back();
    idle();
    addr = 32'h70; wdata = 32'h0BADF00D; mem_write = 1'b1;
    tick();
    idle();
    addr = 32'h70; ld_type = 3'b001;
    tick();
    if (rdata_w !== 32'h0BADF00D) begin errors++; $display("FAIL b2b_lw: got %h expected %h", rdata_w, 32'h0BADF00D); end
    checks++;
    addr = 32'h71; ld_type = 3'b101;
    tick();
    if (rdata_w !== 32'h000000F0 || ld_valid_w !== 1'b1) begin
      errors++; $display("FAIL b2b_lbu: got %h/%b expected %h/1", rdata_w, ld_valid_w, 32'h000000F0);
    end
    checks++;
    do_store(32'h1074, 32'h5EED1234, 2'b00, 2'b00);
    do_load(32'h74, 3'b001, 32'h0);
    if (rdata_w !== 32'h5EED1234) begin errors++; $display("FAIL alias_0x1074: got %h expected %h", rdata_w, 32'h5EED1234); end
    checks++;
  endtask

  task automatic test_reset_suppress();
    idle();
    addr = 32'h50; wdata = 32'hDEADBEEF; mem_write = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    if (rdata_w !== 32'h0) begin errors++; $display("FAIL post_reset_rdata: got %h expected %h", rdata_w, 32'h0); end
    checks++;
    do_load(32'h50, 3'b001, 32'h0);
    if (rdata_w !== 32'h0 || ld_valid_w !== 1'b1) begin
      errors++; $display("FAIL lw_0x50_after_reset: got %h/%b expected %h/1", rdata_w, ld_valid_w, 32'h0);
    end
    checks++;
    do_load(32'h74, 3'b001, 32'h0);
    if (rdata_w !== 32'h0) begin errors++; $display("FAIL mem_cleared_0x74: got %h expected %h", rdata_w, 32'h0); end
    checks++;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    test_reset();
    test_store_load();
    test_sub_word_loads();
    test_partial_stores();
    test_swl_swr();
    test_lwl_lwr();
    test_misaligned();
    test_back_to_back();
    test_reset_suppress();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_data_mem_unit
